// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched_if
// Brief    : Requester / uart_tx side bundle for the shared-transmitter scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_sched_if #(
    parameter int N_REQ = 2
) ();
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_lock;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         sdata;
    logic               tx_start;
    logic               tx_busy;
    logic [2:0]         grant_id;
    logic               sched_busy;

    // master: requesters plus the uart_tx instance; slave: the scheduler
    modport master (
        output req_valid, req_data, req_lock, tx_busy,
        input  req_ready, sdata, tx_start, grant_id, sched_busy
    );
    modport slave (
        input  req_valid, req_data, req_lock, tx_busy,
        output req_ready, sdata, tx_start, grant_id, sched_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Brief    : Round-robin byte scheduler sharing one uart_tx among N_REQ producers.
//            Optional grant locking enabled by defining UART_TX_SCHED_LOCK_EN.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_sched #(
    parameter int N_REQ = 2,
    parameter int GUARD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_sched_if.slave   bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GUARD     = 3'd4;

    localparam int              c_gw         = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [2:0]      c_last       = 3'(N_REQ - 1);
    localparam logic [c_gw-1:0] c_guard_last = (GUARD > 0) ? c_gw'(GUARD - 1) : '0;

    logic [2:0]       r_state;
    logic [2:0]       r_rr;
    logic [c_gw-1:0]  r_guard_cnt;
    logic [N_REQ-1:0] r_req_ready;
    logic [7:0]       r_sdata;
    logic             r_tx_start;
    logic [2:0]       r_grant_id;
    logic             r_sched_busy;

    logic [N_REQ-1:0] w_hi;
    logic [2:0]       w_pick_hi;
    logic [2:0]       w_pick_any;
    logic [2:0]       w_grant;
    logic [N_REQ-1:0] w_grant_oh;
    logic [7:0]       w_grant_data;
    logic             w_take;
    logic [2:0]       w_state_nxt;
    logic [2:0]       w_rr_adv;
    logic [2:0]       w_rr_nxt;

    // Rotating priority: lowest valid index at/after the pointer, else lowest overall
    always_comb begin
        w_hi       = '0;
        w_pick_any = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_hi[i] = bus.req_valid[i] && (3'(i) >= r_rr);
            if (bus.req_valid[i]) begin
                w_pick_any = 3'(i);
            end
        end
    end

    always_comb begin
        w_pick_hi = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_hi[i]) begin
                w_pick_hi = 3'(i);
            end
        end
        w_grant = (|w_hi) ? w_pick_hi : w_pick_any;
    end

    always_comb begin
        w_grant_oh   = '0;
        w_grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_grant_oh[i] = (w_grant == 3'(i));
            w_grant_data  = w_grant_data | (bus.req_data[8*i +: 8] & {8{w_grant_oh[i]}});
        end
    end

    assign w_take   = (r_state == S_IDLE) && (|bus.req_valid) && !bus.tx_busy;
    assign w_rr_adv = (r_grant_id == c_last) ? 3'd0 : r_grant_id + 3'd1;

`ifdef UART_TX_SCHED_LOCK_EN
    // r_req_ready is the grantee's one-hot during S_ISSUE, i.e. the accept cycle
    assign w_rr_nxt = (|(bus.req_lock & r_req_ready)) ? r_grant_id : w_rr_adv;
`else
    assign w_rr_nxt = w_rr_adv;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_take) w_state_nxt = S_ISSUE;
            S_ISSUE:     w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (bus.tx_busy) w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (!bus.tx_busy) w_state_nxt = (GUARD > 0) ? S_GUARD : S_IDLE;
            S_GUARD:     if (r_guard_cnt == c_guard_last) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr         <= '0;
            r_guard_cnt  <= '0;
            r_req_ready  <= '0;
            r_sdata      <= '0;
            r_tx_start   <= 1'b0;
            r_grant_id   <= '0;
            r_sched_busy <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sched_busy <= (w_state_nxt != S_IDLE);
            r_tx_start   <= 1'b0;
            r_req_ready  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_sdata     <= w_grant_data;
                        r_grant_id  <= w_grant;
                        r_tx_start  <= 1'b1;
                        r_req_ready <= w_grant_oh;
                    end
                end
                S_ISSUE:     r_rr        <= w_rr_nxt;
                S_WAIT_DONE: r_guard_cnt <= '0;
                S_GUARD:     r_guard_cnt <= r_guard_cnt + c_gw'(1);
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.sdata      = r_sdata;
    assign bus.tx_start   = r_tx_start;
    assign bus.grant_id   = r_grant_id;
    assign bus.sched_busy = r_sched_busy;
endmodule
`default_nettype wire
